peripheral_dbg_pu_riscv_cpu_sched: RTL and testbench

Scheduler and stall controller for the per-core CPU debug ports of the RISC-V debug unit. Accepts one register access at a time from the debug module, routes it to exactly one of CORES cores (X·Y·Z·CORES_PER_TILE flattened), and enforces that only stalled cores are accessed. Owns every core's stall line and handles breakpoint-triggered halts, optionally halting all cores. Sits between the debug module's CPU command channel and the core-side cpu_* ports.

---
 rtl/peripheral_dbg_pu_riscv_cpu_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_peripheral_dbg_pu_riscv_cpu_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_dbg_pu_riscv_cpu_sched.sv
`default_nettype none
// peripheral_dbg_pu_riscv_cpu_sched: routes one debug register access at a time to a stalled core,
// owns every core's stall line and breakpoint halts.  Rev 1.0
module peripheral_dbg_pu_riscv_cpu_sched #(
    parameter int CORES          = 32,
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255,
    localparam int CW            = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                                cpu_clk_i,
    input  logic                                cpu_rstn_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [CW-1:0]                       req_core_i,
    input  logic                                req_we_i,
    input  logic [CPU_ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [CPU_DATA_WIDTH-1:0]           req_data_i,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic [CPU_DATA_WIDTH-1:0]           resp_data_o,
    output logic                                resp_err_o,
    input  logic [CORES-1:0]                    stall_set_i,
    input  logic [CORES-1:0]                    stall_clr_i,
    input  logic                                halt_all_i,
    output logic [CORES-1:0]                    stall_status_o,
    output logic [CORES-1:0]                    bp_hit_o,
    output logic [CORES*CPU_ADDR_WIDTH-1:0]     cpu_addr_o,
    output logic [CORES*CPU_DATA_WIDTH-1:0]     cpu_data_o,
    input  logic [CORES*CPU_DATA_WIDTH-1:0]     cpu_data_i,
    output logic [CORES-1:0]                    cpu_stb_o,
    output logic [CORES-1:0]                    cpu_we_o,
    input  logic [CORES-1:0]                    cpu_ack_i,
    input  logic [CORES-1:0]                    cpu_bp_i,
    output logic [CORES-1:0]                    cpu_stall_o
);

    localparam int AW = CPU_ADDR_WIDTH;
    localparam int DW = CPU_DATA_WIDTH;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       core_q;
    logic                we_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       data_q;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DW-1:0]       resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic [CORES-1:0]    stall_q, stall_d, bp_hit_q, bp_hit_d;
    logic [CORES-1:0]    stb_q, stb_d, cwe_q, cwe_d;
    logic [CORES*AW-1:0] caddr_q, caddr_d;
    logic [CORES*DW-1:0] cdata_q, cdata_d;

    logic                accept, req_bad, req_stalled, ack_sel, timeout_hit, bp_any, clr_ok;
    logic [DW-1:0]       rdata_sel;
    logic [CW-1:0]       sel_core;
    logic                sel_we;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_data;

    // Per-core lookups done by compare rather than indexing so odd CORES counts never read out of range
    always_comb begin
        req_stalled = 1'b0;
        ack_sel     = 1'b0;
        rdata_sel   = '0;
        for (int n = 0; n < CORES; n++) begin
            if (req_core_i == CW'(n)) req_stalled = stall_q[n];
            if (core_q == CW'(n)) begin
                ack_sel   = cpu_ack_i[n];
                rdata_sel = cpu_data_i[n*DW +: DW];
            end
        end
    end

    assign accept      = req_valid_i & ready_q;
    assign req_bad     = ({1'b0, req_core_i} >= (CW+1)'(CORES)) | ~req_stalled;
    assign timeout_hit = (cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_bad ? S_RESP : S_ACCESS;
            S_ACCESS: if (ack_sel || timeout_hit) state_d = S_RESP;
            S_RESP:   if (resp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d      = (state_d == S_IDLE);
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept && req_bad) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                end
            end
            S_ACCESS: begin
                // An ack on the final timeout cycle still completes the access
                if (ack_sel) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = we_q ? '0 : rdata_sel;
                    resp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase

        sel_core = (state_q == S_IDLE) ? req_core_i : core_q;
        sel_we   = (state_q == S_IDLE) ? req_we_i   : we_q;
        sel_addr = (state_q == S_IDLE) ? req_addr_i : addr_q;
        sel_data = (state_q == S_IDLE) ? req_data_i : data_q;
        for (int n = 0; n < CORES; n++) begin
            stb_d[n]             = (state_d == S_ACCESS) && (sel_core == CW'(n));
            cwe_d[n]             = stb_d[n] & sel_we;
            caddr_d[n*AW +: AW]  = stb_d[n] ? sel_addr : '0;
            cdata_d[n*DW +: DW]  = stb_d[n] ? sel_data : '0;
        end
    end

    // Stall priority per core: breakpoint > set > clear; the core under access cannot be released
    always_comb begin
        bp_any   = |cpu_bp_i;
        stall_d  = stall_q;
        bp_hit_d = bp_hit_q;
        clr_ok   = 1'b0;
        for (int n = 0; n < CORES; n++) begin
            clr_ok = stall_clr_i[n] && !((state_q == S_ACCESS) && (core_q == CW'(n)));
            if (cpu_bp_i[n] || (halt_all_i && bp_any)) begin
                stall_d[n] = 1'b1;
            end else if (stall_set_i[n]) begin
                stall_d[n] = 1'b1;
            end else if (clr_ok) begin
                stall_d[n]  = 1'b0;
                bp_hit_d[n] = 1'b0;
            end
            if (cpu_bp_i[n]) bp_hit_d[n] = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            core_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            stall_q      <= '0;
            bp_hit_q     <= '0;
            stb_q        <= '0;
            cwe_q        <= '0;
            caddr_q      <= '0;
            cdata_q      <= '0;
        end else begin
            if (accept) begin
                core_q <= req_core_i;
                we_q   <= req_we_i;
                addr_q <= req_addr_i;
                data_q <= req_data_i;
            end
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            stall_q      <= stall_d;
            bp_hit_q     <= bp_hit_d;
            stb_q        <= stb_d;
            cwe_q        <= cwe_d;
            caddr_q      <= caddr_d;
            cdata_q      <= cdata_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_data_o    = resp_data_q;
    assign resp_err_o     = resp_err_q;
    assign stall_status_o = stall_q;
    assign cpu_stall_o    = stall_q;
    assign bp_hit_o       = bp_hit_q;
    assign cpu_stb_o      = stb_q;
    assign cpu_we_o       = cwe_q;
    assign cpu_addr_o     = caddr_q;
    assign cpu_data_o     = cdata_q;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_dbg_pu_riscv_cpu_sched.sv
`default_nettype none
// tb_peripheral_dbg_pu_riscv_cpu_sched: directed vector table plus hand-written corner sequences.
// Rev 1.0
module tb_peripheral_dbg_pu_riscv_cpu_sched;

    localparam int N  = 32;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid, req_ready, req_we;
    logic [CW-1:0]     req_core;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_data;
    logic              resp_valid, resp_ready, resp_err;
    logic [DW-1:0]     resp_data;
    logic [N-1:0]      stall_set, stall_clr, stall_status, bp_hit;
    logic              halt_all;
    logic [N*AW-1:0]   cpu_addr;
    logic [N*DW-1:0]   cpu_wdata, cpu_rdata;
    logic [N-1:0]      cpu_stb, cpu_we, cpu_ack, cpu_bp, cpu_stall;

    int passed = 0;
    int total  = 0;

    peripheral_dbg_pu_riscv_cpu_sched #(
        .CORES(N), .CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .cpu_clk_i(clk), .cpu_rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_core_i(req_core),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_err_o(resp_err),
        .stall_set_i(stall_set), .stall_clr_i(stall_clr), .halt_all_i(halt_all),
        .stall_status_o(stall_status), .bp_hit_o(bp_hit),
        .cpu_addr_o(cpu_addr), .cpu_data_o(cpu_wdata), .cpu_data_i(cpu_rdata),
        .cpu_stb_o(cpu_stb), .cpu_we_o(cpu_we), .cpu_ack_i(cpu_ack), .cpu_bp_i(cpu_bp),
        .cpu_stall_o(cpu_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stalled;
        int          ack_at;   // stb cycle (1-based) on which the core acks; 0 = never
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;  // cycles from accept edge to resp_valid
        int          exp_stb;  // number of cycles the target strobe is high
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!req_ready && c < 10) begin
            step();
            c++;
        end
        if (!req_ready) check("req_ready_wait", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic send(input logic [CW-1:0] core, input logic we, input logic [31:0] addr,
                        input logic [31:0] data);
        wait_ready();
        req_valid = 1'b1;
        req_core  = core;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] idx;
        logic [N-1:0]  tgt, spur;
        int            lat, stbcnt;
        bit            got, foreign;
        logic [31:0]   held;

        vecs[0] = '{5,  1'b0, 32'h10,   32'h0,        1'b1, 4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 5, 4};
        vecs[1] = '{3,  1'b1, 32'h20,   32'h11112222, 1'b0, 1, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[2] = '{40, 1'b0, 32'h24,   32'h0,        1'b0, 1, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[3] = '{0,  1'b0, 32'h30,   32'h0,        1'b1, 0, 32'h55555555, 1'b1, 32'h0,        5, 4};
        vecs[4] = '{0,  1'b0, 32'h34,   32'h0,        1'b1, 4, 32'h12345678, 1'b0, 32'h12345678, 5, 4};
        vecs[5] = '{31, 1'b1, 32'h7FC,  32'hCAFE0031, 1'b1, 1, 32'hFFFFFFFF, 1'b0, 32'h0,        2, 1};
        vecs[6] = '{12, 1'b0, 32'h100,  32'h0,        1'b1, 2, 32'hA5A50001, 1'b0, 32'hA5A50001, 3, 2};

        rstn = 1'b0; req_valid = 1'b0; req_core = '0; req_we = 1'b0; req_addr = '0; req_data = '0;
        resp_ready = 1'b0; stall_set = '0; stall_clr = '0; halt_all = 1'b0;
        cpu_ack = '0; cpu_bp = '0;
        for (int n = 0; n < N; n++) cpu_rdata[n*DW +: DW] = 32'hBAD00000 | 32'(n);

        // Reset state
        step(); step();
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_stall", {32'd0, cpu_stall}, 64'd0);
        check("rst_stb", {32'd0, cpu_stb}, 64'd0);
        rstn = 1'b1;
        step(); step();
        check("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Table-driven transactions
        for (int v = 0; v < 7; v++) begin
            idx  = vecs[v].core[CW-1:0];
            tgt  = N'(1) << idx;
            spur = N'(1) << (idx ^ 5'd1);
            if (vecs[v].stalled) stall_set = tgt;
            else                 stall_clr = tgt;
            step();
            stall_set = '0; stall_clr = '0;
            cpu_rdata[idx*DW +: DW] = vecs[v].rdata;
            cpu_ack = spur;
            send(idx, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            got = 0; lat = 0; stbcnt = 0; foreign = 0;
            for (int c = 1; c <= 20 && !got; c++) begin
                if (resp_valid) begin
                    got = 1;
                    lat = c;
                end else begin
                    if ((cpu_stb & ~tgt) != '0) foreign = 1;
                    cpu_ack = spur;
                    if (cpu_stb[idx]) begin
                        stbcnt++;
                        if (stbcnt == 1) begin
                            check($sformatf("v%0d_addr", v), {32'd0, cpu_addr[idx*AW +: AW]},
                                  {32'd0, vecs[v].addr});
                            check($sformatf("v%0d_we", v), {63'd0, cpu_we[idx]}, {63'd0, vecs[v].we});
                            check($sformatf("v%0d_wdata", v), {32'd0, cpu_wdata[idx*DW +: DW]},
                                  {32'd0, vecs[v].wdata});
                        end
                        if (stbcnt == vecs[v].ack_at) cpu_ack = spur | tgt;
                    end
                    step();
                end
            end
            cpu_ack = '0;
            check($sformatf("v%0d_resp_seen", v), {63'd0, got}, 64'd1);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            check($sformatf("v%0d_stb_cycles", v), 64'(stbcnt), 64'(vecs[v].exp_stb));
            check($sformatf("v%0d_err", v), {63'd0, resp_err}, {63'd0, vecs[v].exp_err});
            check($sformatf("v%0d_data", v), {32'd0, resp_data}, {32'd0, vecs[v].exp_data});
            check($sformatf("v%0d_foreign_stb", v), {63'd0, foreign}, 64'd0);
            finish_resp();
            check($sformatf("v%0d_resp_done", v), {63'd0, resp_valid}, 64'd0);
            cpu_rdata[idx*DW +: DW] = 32'hBAD00000 | 32'(idx);
        end

        // Breakpoint with halt_all stalls everything; clear on the breaking core releases it
        stall_clr = '1;
        step();
        stall_clr = '0;
        check("pre_bp_stall", {32'd0, cpu_stall}, 64'd0);
        cpu_bp = N'(1) << 7;
        halt_all = 1'b1;
        step();
        cpu_bp = '0;
        halt_all = 1'b0;
        check("bp_all_stalled", {32'd0, cpu_stall}, 64'hFFFFFFFF);
        check("bp_hit_7", {32'd0, bp_hit}, 64'h80);
        stall_clr = N'(1) << 7;
        step();
        stall_clr = '0;
        check("bp_clr_stall", {32'd0, stall_status}, 64'hFFFFFF7F);
        check("bp_clr_hit", {32'd0, bp_hit}, 64'h0);

        // Clear on the accessed core is ignored; set+clr on core 2 leaves it stalled
        stall_clr = N'(1) << 2;
        step();
        stall_clr = '0;
        check("core2_released", {63'd0, stall_status[2]}, 64'd0);
        send(5'd9, 1'b0, 32'h44, 32'h0);
        check("c9_stb", {63'd0, cpu_stb[9]}, 64'd1);
        stall_clr = (N'(1) << 9) | (N'(1) << 2);
        stall_set = N'(1) << 2;
        step();
        stall_clr = '0; stall_set = '0;
        check("clr_ignored_in_access", {63'd0, stall_status[9]}, 64'd1);
        check("set_beats_clr", {63'd0, stall_status[2]}, 64'd1);
        cpu_ack = N'(1) << 9;
        step();
        cpu_ack = '0;
        check("c9_resp", {62'd0, resp_valid, resp_err}, 64'd2);
        finish_resp();
        check("clr_not_deferred", {63'd0, stall_status[9]}, 64'd1);

        // Back-pressured response stays stable
        cpu_rdata[9*DW +: DW] = 32'hCAFEF00D;
        send(5'd9, 1'b0, 32'h48, 32'h0);
        cpu_ack = N'(1) << 9;
        step();
        cpu_ack = '0;
        held = resp_data;
        check("bp_resp_data", {32'd0, held}, 64'hCAFEF00D);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d", c), {61'd0, resp_valid, req_ready, resp_data == held}, 64'h5);
            step();
        end
        finish_resp();
        check("hold_released", {62'd0, resp_valid, req_ready}, 64'd1);

        // Async reset in the middle of an access
        stall_set = N'(1) << 4;
        step();
        stall_set = '0;
        send(5'd4, 1'b1, 32'h50, 32'h77);
        check("pre_rst_stb", {63'd0, cpu_stb[4]}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_outs", {29'd0, cpu_stb, resp_valid, req_ready, 1'b0},
              {29'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        check("async_rst_stall", {32'd0, cpu_stall}, 64'd0);
        step();
        rstn = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid || cpu_stb != '0) got = 1;
            step();
        end
        check("no_resp_after_rst", {63'd0, got}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
